// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC sequencing, instruction-memory handshake,
// one-entry skid buffer for stalls and a discard state for redirects that
// land while a read is still outstanding.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Stall,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic [31:0] ImemData,
   output logic [31:0] Instruction,
   output logic [31:0] PCAddResult,
   output logic        IFValid,
   output logic        FetchFlush
);

   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

   state_t      r_state,        w_state_nxt;
   logic [31:0] r_pc,           w_pc_nxt;
   logic [31:0] r_instr,        w_instr_nxt;
   logic [31:0] r_pc4,          w_pc4_nxt;
   logic        r_valid,        w_valid_nxt;
   logic [31:0] r_skid_data,    w_skid_data_nxt;
   logic [31:0] r_skid_pc4,     w_skid_pc4_nxt;
   logic [31:0] r_discard_addr, w_discard_addr_nxt;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;

   assign w_redirect  = Jump | BranchTaken;
   assign w_target    = Jump ? {JumpTarget[31:2], 2'b00} : {BranchTarget[31:2], 2'b00};
   assign w_pc_plus4  = r_pc + 32'd4;

   assign FetchFlush  = w_redirect;
   // Gated with rst_n so no request is visible while reset is held.
   assign ImemReq     = rst_n & (r_state != HOLD);
   assign ImemAddr    = (r_state == DISCARD) ? r_discard_addr : r_pc;
   assign Instruction = r_instr;
   assign PCAddResult = r_pc4;
   assign IFValid     = r_valid;

   // Next-state and next-register computation; every register holds by default.
   always_comb begin
      w_state_nxt        = r_state;
      w_pc_nxt           = r_pc;
      w_instr_nxt        = r_instr;
      w_pc4_nxt          = r_pc4;
      w_valid_nxt        = r_valid;
      w_skid_data_nxt    = r_skid_data;
      w_skid_pc4_nxt     = r_skid_pc4;
      w_discard_addr_nxt = r_discard_addr;

      if (w_redirect) begin
         w_pc_nxt        = w_target;
         w_instr_nxt     = NOP;
         w_pc4_nxt       = '0;
         w_valid_nxt     = 1'b0;
         w_skid_data_nxt = '0;
         w_skid_pc4_nxt  = '0;
         // An ack arriving with the redirect retires the outstanding read,
         // so only an unacknowledged request has to be waited out.
         if ((r_state == FETCH) && !ImemAck) begin
            w_state_nxt        = DISCARD;
            w_discard_addr_nxt = r_pc;
         end else if ((r_state == DISCARD) && !ImemAck) begin
            w_state_nxt = DISCARD;
         end else begin
            w_state_nxt = FETCH;
         end
      end else begin
         case (r_state)
            FETCH: begin
               if (ImemAck) begin
                  w_pc_nxt = w_pc_plus4;
                  if (Stall) begin
                     w_skid_data_nxt = ImemData;
                     w_skid_pc4_nxt  = w_pc_plus4;
                     w_state_nxt     = HOLD;
                  end else begin
                     w_instr_nxt = ImemData;
                     w_pc4_nxt   = w_pc_plus4;
                     w_valid_nxt = 1'b1;
                  end
               end else if (!Stall) begin
                  w_instr_nxt = NOP;
                  w_valid_nxt = 1'b0;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  w_instr_nxt = r_skid_data;
                  w_pc4_nxt   = r_skid_pc4;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = FETCH;
               end
            end
            DISCARD: begin
               if (ImemAck) begin
                  w_state_nxt = FETCH;
               end
            end
            default: w_state_nxt = FETCH;
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= FETCH;
         r_pc           <= RESET_PC;
         r_instr        <= NOP;
         r_pc4          <= '0;
         r_valid        <= 1'b0;
         r_skid_data    <= '0;
         r_skid_pc4     <= '0;
         r_discard_addr <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_pc           <= w_pc_nxt;
         r_instr        <= w_instr_nxt;
         r_pc4          <= w_pc4_nxt;
         r_valid        <= w_valid_nxt;
         r_skid_data    <= w_skid_data_nxt;
         r_skid_pc4     <= w_skid_pc4_nxt;
         r_discard_addr <= w_discard_addr_nxt;
      end
   end

endmodule
